riscv_multicycle_ctrl: RTL

- Main control FSM plus ALU/immediate decoders for the multicycle RV32I core on the iceBlinkPico.
- Sequences a shared datapath (PC, IR, OldPC, register file, ALU, single unified memory) through fetch, decode, execute, memory and writeback steps.
- Stalls on a `mem_ready` handshake so block RAM with variable latency can sit behind the single memory port.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq and jal.

---
 rtl/riscv_multicycle_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: main control FSM with ALU and immediate decoders for the multicycle RV32I core.
// Ports: clk, reset (sync, active-low); op/funct3/funct7b5 from IR; Zero from ALU; mem_ready from memory.
// Outputs: datapath strobes (PCWrite, IRWrite, RegWrite, MemWrite), mux selects, ImmSrc, ALUControl,
// a retire pulse per completed instruction and an illegal-opcode flag.
// Optional: define CTRL_ILLEGAL_TRAP_EN to lock up in a TRAP state on unknown opcodes instead of NOP.
module riscv_multicycle_ctrl #(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 RegWrite,
  output logic                 retire,
  output logic                 illegal
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;
  state_t state, next;
  logic [1:0] alu_op;
  logic [2:0] alu_dec;
  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else state <= next;
  end
  always_comb begin
    next = state;
    PCWrite = 1'b0;
    AdrSrc = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    RegWrite = 1'b0;
    retire = 1'b0;
    alu_op = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECR;
          OP_I:         next = EXECI;
          OP_BEQ:       next = BEQ;
          OP_JAL:       next = JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      next = TRAP;
`else
          default: begin
            retire = 1'b1;
            next = FETCH;
          end
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next = (op == OP_LW) ? MEMREAD : MEMWR;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemWrite = 1'b1;
        retire = mem_ready;
        next = mem_ready ? FETCH : MEMWR;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op = 2'b10;
        next = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op = 2'b10;
        next = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op = 2'b01;
        PCWrite = Zero;
        retire = 1'b1;
        next = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        next = ALUWB;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP: next = TRAP;
`endif
      default: next = FETCH;
    endcase
    // Strobes are suppressed while reset is held so an abandoned instruction cannot write anything.
    if (!reset) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      retire = 1'b0;
    end
  end
  // Only register-register ops (op[5]=1) turn funct3=000 into sub; addi ignores instr[30].
  always_comb begin
    alu_dec = alu_op == 2'b00 ? 3'b000 :
              alu_op == 2'b01 ? 3'b001 :
              funct3 == 3'b000 ? {2'b00, op[5] & funct7b5} :
              funct3 == 3'b010 ? 3'b101 :
              funct3 == 3'b110 ? 3'b011 :
              funct3 == 3'b111 ? 3'b010 : 3'b000;
    ImmSrc = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
  end
  assign ALUControl = ALUCTRL_W'(alu_dec);
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state == TRAP);
`else
  assign illegal = 1'b0;
`endif
endmodule
